// File: rtl/baud_tick_gen_frac_if.sv
// Control/status bundle for baud_tick_gen_frac.
//   master: drives en, sync_clr, cfg_load, cfg_int, cfg_frac;
//           observes sample_tick, bit_tick, os_phase, cfg_pending.
//   slave : the generator itself (directions reversed).
interface baud_tick_gen_frac_if #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16
);
    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic              en;
    logic              sync_clr;
    logic              cfg_load;
    logic [DIV_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_frac;
    logic              sample_tick;
    logic              bit_tick;
    logic [OS_W-1:0]   os_phase;
    logic              cfg_pending;

    modport master (
        output en, sync_clr, cfg_load, cfg_int, cfg_frac,
        input  sample_tick, bit_tick, os_phase, cfg_pending
    );

    modport slave (
        input  en, sync_clr, cfg_load, cfg_int, cfg_frac,
        output sample_tick, bit_tick, os_phase, cfg_pending
    );
endinterface

// File: rtl/baud_tick_gen_frac.sv
// Fractional baud tick generator.
// Emits a 1-cycle sample_tick every act_int (+1 when the fractional
// accumulator carries) cycles, and a 1-cycle bit_tick on every OVERSAMPLE-th
// sample tick. A new divisor is staged in a shadow register and applied only
// at a safe point (terminal count, sync_clr, or while disabled).
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - slave side of baud_tick_gen_frac_if (control in, ticks/status out)
module baud_tick_gen_frac #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16,
    parameter int RESET_INT  = 27,
    parameter int RESET_FRAC = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    baud_tick_gen_frac_if.slave   bus
);
    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]   OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0]  MIN_INT = DIV_W'(2);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
    logic              carry_q, carry_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic              sample_tick_q, sample_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              pending_q, pending_d;
    logic [DIV_W-1:0]  sh_int_q, sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;

    logic [DIV_W:0]    period;
    logic [FRAC_W:0]   frac_sum;
    logic              terminal;
    logic              apply;

    always_comb begin
        period   = {1'b0, act_int_q} + {{DIV_W{1'b0}}, carry_q};
        frac_sum = {1'b0, frac_acc_q} + {1'b0, act_frac_q};
        // >= rather than == so a divisor shrunk while disabled cannot make
        // the counter run past its terminal value and wrap.
        terminal = bus.en && !bus.sync_clr &&
                   ({1'b0, cnt_q} >= (period - (DIV_W+1)'(1)));
        apply    = pending_q && (bus.sync_clr || !bus.en || terminal);

        cnt_d         = cnt_q;
        frac_acc_d    = frac_acc_q;
        carry_d       = carry_q;
        os_cnt_d      = os_cnt_q;
        sample_tick_d = 1'b0;
        bit_tick_d    = 1'b0;
        pending_d     = pending_q;
        sh_int_d      = sh_int_q;
        sh_frac_d     = sh_frac_q;
        act_int_d     = act_int_q;
        act_frac_d    = act_frac_q;

        if (bus.sync_clr) begin
            cnt_d      = '0;
            frac_acc_d = '0;
            carry_d    = 1'b0;
            os_cnt_d   = '0;
        end else if (bus.en) begin
            if (terminal) begin
                cnt_d         = '0;
                sample_tick_d = 1'b1;
                {carry_d, frac_acc_d} = frac_sum;
                bit_tick_d    = (os_cnt_q == OS_LAST);
                os_cnt_d      = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        // Apply uses the shadow as it was before this cycle's cfg_load.
        if (apply) begin
            act_int_d  = (sh_int_q < MIN_INT) ? MIN_INT : sh_int_q;
            act_frac_d = sh_frac_q;
        end

        if (bus.cfg_load) begin
            sh_int_d  = bus.cfg_int;
            sh_frac_d = bus.cfg_frac;
            pending_d = 1'b1;
        end else if (apply) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            frac_acc_q    <= '0;
            carry_q       <= 1'b0;
            os_cnt_q      <= '0;
            sample_tick_q <= 1'b0;
            bit_tick_q    <= 1'b0;
            pending_q     <= 1'b0;
            sh_int_q      <= DIV_W'(RESET_INT);
            sh_frac_q     <= FRAC_W'(RESET_FRAC);
            act_int_q     <= DIV_W'(RESET_INT);
            act_frac_q    <= FRAC_W'(RESET_FRAC);
        end else begin
            cnt_q         <= cnt_d;
            frac_acc_q    <= frac_acc_d;
            carry_q       <= carry_d;
            os_cnt_q      <= os_cnt_d;
            sample_tick_q <= sample_tick_d;
            bit_tick_q    <= bit_tick_d;
            pending_q     <= pending_d;
            sh_int_q      <= sh_int_d;
            sh_frac_q     <= sh_frac_d;
            act_int_q     <= act_int_d;
            act_frac_q    <= act_frac_d;
        end
    end

    assign bus.sample_tick = sample_tick_q;
    assign bus.bit_tick    = bit_tick_q;
    assign bus.os_phase    = os_cnt_q;
    assign bus.cfg_pending = pending_q;
endmodule
